// File: rtl/mem_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_ctrl_if
// Description : Memory-side read bus between mem_read_ctrl (master) and the
//               memory (slave): read strobe, address, data-valid acknowledge
//               and read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_read_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20
);
    logic              mem_en;     // one-cycle read strobe
    logic [ADDR_W-1:0] mem_addr;   // registered read address
    logic              mem_ack;    // read data valid
    logic [DATA_W-1:0] mem_rdata;  // read data, valid with mem_ack

    // Controller side: issues the strobe/address, receives ack/data
    modport master (
        output mem_en,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    // Memory side: receives the strobe/address, returns ack/data
    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface : mem_read_ctrl_if
`default_nettype wire

// File: rtl/mem_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_ctrl
// Description : Single-outstanding memory read controller. A CPU read request
//               sampled in IDLE captures the address, strobes the memory for
//               one cycle, waits for mem_ack, loads the returned word into Ro
//               and pulses rd_done. Back-to-back reads take 4 cycles each.
//               Optional feature macro: MEM_READ_TIMEOUT_EN - abandons a read
//               after TIMEOUT unacknowledged wait cycles and pulses rd_err.
//               Without it there is no wait counter and rd_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 20,
    parameter int TIMEOUT = 15
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    // CPU side
    input  wire logic              rd_req,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic                   busy,
    // Memory side
    mem_read_ctrl_if.master        mem,
    // Downstream read register side
    output logic [DATA_W-1:0]      Ro,
    output logic                   rd_done,
    output logic                   rd_err
);

    // ------------------------------------------------------------------------
    // Parameter sanity: a zero timeout would abort every read immediately
    // ------------------------------------------------------------------------
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mem_read_ctrl: TIMEOUT must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_ro;

    logic                w_capture;   // take rd_addr into mem_addr
    logic                w_load_ro;   // take mem_rdata into Ro
    logic                w_busy;
    logic                w_mem_en;
    logic                w_rd_done;

`ifdef MEM_READ_TIMEOUT_EN
    // Counter must be able to hold the value TIMEOUT itself
    localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout_cnt = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic                w_timeout;   // give up on the current read
    logic                r_rd_err;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and Moore/strobe decode
    // mem_ack is only looked at in WAIT, so an early or stray ack is harmless.
    // An ack in the cycle the counter reaches TIMEOUT wins over the timeout.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load_ro   = 1'b0;
        w_busy      = 1'b0;
        w_mem_en    = 1'b0;
        w_rd_done   = 1'b0;
`ifdef MEM_READ_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (rd_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_busy      = 1'b1;
                w_mem_en    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (mem.mem_ack) begin
                    w_load_ro   = 1'b1;
                    w_state_nxt = ST_DONE;
`ifdef MEM_READ_TIMEOUT_EN
                end else if (r_wait_cnt == c_timeout_cnt) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            ST_DONE: begin
                // Requests here are dropped; the next read starts from IDLE
                w_rd_done   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address register: holds from one capture to the next
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
        end else if (w_capture) begin
            r_mem_addr <= rd_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Read-data register: changes only on an ack accepted in WAIT
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ro <= '0;
        end else if (w_load_ro) begin
            r_ro <= mem.mem_rdata;
        end
    end

`ifdef MEM_READ_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Wait counter: cleared in ISSUE, counts unacknowledged WAIT cycles
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !mem.mem_ack && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Error pulse: one cycle, in the first IDLE cycle after the timeout
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_err <= 1'b0;
        end else begin
            r_rd_err <= w_timeout;
        end
    end

    assign rd_err = r_rd_err;
`else
    assign rd_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign busy         = w_busy;
    assign rd_done      = w_rd_done;
    assign Ro           = r_ro;
    assign mem.mem_en   = w_mem_en;
    assign mem.mem_addr = r_mem_addr;

endmodule : mem_read_ctrl
`default_nettype wire

// File: tb/tb_mem_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_ctrl
// Description : Directed self-checking bench for mem_read_ctrl. Inputs are
//               driven and outputs sampled just after the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_ctrl;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 20;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic [DATA_W-1:0] Ro;
    logic              rd_done;
    logic              rd_err;

    int n_pass;
    int n_total;
    logic [DATA_W-1:0] exp_ro;
    logic [ADDR_W-1:0] exp_addr;

    mem_read_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_read_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .busy    (busy),
        .mem     (mem_bus),
        .Ro      (Ro),
        .rd_done (rd_done),
        .rd_err  (rd_err)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Full read from IDLE; called and returns just after a falling edge.
    task automatic run_read(input logic [ADDR_W-1:0] addr, input int ack_delay,
                            input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] ro_before);
        rd_req  = 1'b1;
        rd_addr = addr;
        @(negedge clk);                               // ISSUE
        check("issue_mem_en", 32'(mem_bus.mem_en), 32'd1);
        check("issue_mem_addr", 32'(mem_bus.mem_addr), 32'(addr));
        check("issue_busy", 32'(busy), 32'd1);
        rd_req = 1'b0;
        @(negedge clk);                               // WAIT, count 0
        check("wait_mem_en", 32'(mem_bus.mem_en), 32'd0);
        for (int i = 0; i < ack_delay; i++) begin
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_ro_hold", 32'(Ro), 32'(ro_before));
            check("wait_rd_err", 32'(rd_err), 32'd0);
            @(negedge clk);
        end
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = data;
        @(negedge clk);                               // DONE
        check("done_rd_done", 32'(rd_done), 32'd1);
        check("done_ro", 32'(Ro), 32'(data));
        check("done_busy", 32'(busy), 32'd0);
        check("done_rd_err", 32'(rd_err), 32'd0);
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);                               // IDLE
        check("idle_rd_done", 32'(rd_done), 32'd0);
        check("idle_rd_err", 32'(rd_err), 32'd0);
        check("idle_mem_addr_hold", 32'(mem_bus.mem_addr), 32'(addr));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_ro  = '0;
        exp_addr = '0;
        rst_n   = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_bus.mem_en), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_ro", 32'(Ro), 32'd0);

        // ---------- first read, accepted on first edge after reset ----------
        rst_n = 1'b1;
        run_read(12'h00A, 0, 20'hAAAAA, exp_ro);
        exp_ro = 20'hAAAAA;

        // ---------- ack outside WAIT is ignored ----------
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 20'h77777;
        repeat (2) begin
            @(negedge clk);
            check("stray_ack_ro", 32'(Ro), 32'(exp_ro));
            check("stray_ack_busy", 32'(busy), 32'd0);
            check("stray_ack_done", 32'(rd_done), 32'd0);
        end
        mem_bus.mem_ack = 1'b0;

        // ---------- delayed ack ----------
        run_read(12'h3C5, 5, 20'h12345, exp_ro);
        exp_ro = 20'h12345;

        // ---------- back-to-back: request held 10 cycles, ack always high ----
        // Cycle c has phase c%4: IDLE, ISSUE, WAIT, DONE.
        exp_addr = 12'h3C5;
        for (int c = 0; c < 12; c++) begin
            rd_req            = (c < 10);
            rd_addr           = 12'(12'h100 + c);
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = 20'(20'h10000 + c);
            if ((c % 4) == 0 && c < 10) exp_addr = 12'(12'h100 + c);
            if ((c % 4) == 2) exp_ro = 20'(20'h10000 + c);
            @(negedge clk);
            check("b2b_mem_en", 32'(mem_bus.mem_en), ((c + 1) % 4 == 1) ? 32'd1 : 32'd0);
            check("b2b_rd_done", 32'(rd_done), ((c + 1) % 4 == 3) ? 32'd1 : 32'd0);
            check("b2b_busy", 32'(busy), (((c + 1) % 4 == 1) || ((c + 1) % 4 == 2)) ? 32'd1 : 32'd0);
            check("b2b_mem_addr", 32'(mem_bus.mem_addr), 32'(exp_addr));
            check("b2b_ro", 32'(Ro), 32'(exp_ro));
        end
        rd_req          = 1'b0;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check("b2b_end_busy", 32'(busy), 32'd0);
        check("b2b_end_ro", 32'(Ro), 32'h1000A);

`ifdef MEM_READ_TIMEOUT_EN
        // ---------- timeout: no ack ----------
        run_read(12'h00A, 0, 20'hAAAAA, exp_ro);
        exp_ro  = 20'hAAAAA;
        rd_req  = 1'b1;
        rd_addr = 12'h0B0;
        @(negedge clk);                               // ISSUE
        rd_req = 1'b0;
        @(negedge clk);                               // WAIT, count 0
        for (int i = 0; i <= TIMEOUT; i++) begin
            check("to_wait_busy", 32'(busy), 32'd1);
            check("to_wait_rd_err", 32'(rd_err), 32'd0);
            @(negedge clk);
        end
        check("to_rd_err", 32'(rd_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_rd_done", 32'(rd_done), 32'd0);
        check("to_ro_kept", 32'(Ro), 32'hAAAAA);
        @(negedge clk);
        check("to_rd_err_pulse", 32'(rd_err), 32'd0);

        // ---------- ack exactly at count TIMEOUT wins ----------
        run_read(12'h0C0, TIMEOUT, 20'h0BEEF, exp_ro);
        exp_ro = 20'h0BEEF;
`else
        // ---------- no timeout: WAIT persists until the ack ----------
        run_read(12'h222, 30, 20'h0F00D, exp_ro);
        exp_ro = 20'h0F00D;
`endif

        // ---------- reset mid-read ----------
        rd_req  = 1'b1;
        rd_addr = 12'h0F0;
        @(negedge clk);                               // ISSUE
        rd_req = 1'b0;
        @(negedge clk);                               // WAIT
        check("mid_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ro", 32'(Ro), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("mid_rst_mem_en", 32'(mem_bus.mem_en), 32'd0);
        @(negedge clk);
        rst_n             = 1'b1;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 20'h55555;
        repeat (3) begin
            @(negedge clk);
            check("mid_ack_ro", 32'(Ro), 32'd0);
            check("mid_ack_rd_done", 32'(rd_done), 32'd0);
            check("mid_ack_rd_err", 32'(rd_err), 32'd0);
            check("mid_ack_busy", 32'(busy), 32'd0);
        end
        mem_bus.mem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_read_ctrl
`default_nettype wire

// File: doc/mem_read_ctrl.md
MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 20, read-data width, matching the 20-bit Ro input of the downstream read register.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the maximum wait cycles for mem_ack.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port rd_req  input  1  CPU read request; sampled only in IDLE.
REQ-007 The block SHALL have port rd_addr  input  ADDR_W  read address, captured with rd_req.
REQ-008 The block SHALL have port busy  output  1  high while a read is in progress.
REQ-009 The block SHALL have port mem_en  output  1  memory read strobe.
REQ-010 The block SHALL have port mem_addr  output  ADDR_W  registered address to memory.
REQ-011 The block SHALL have port mem_ack  input  1  memory data-valid acknowledge.
REQ-012 The block SHALL have port mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1.
REQ-013 The block SHALL have port Ro  output  DATA_W  captured word driving the downstream read register.
REQ-014 The block SHALL have port rd_done  output  1  one-cycle pulse: Ro updated.
REQ-015 The block SHALL have port rd_err  output  1  one-cycle pulse: read timed out.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: on rd_req=1, capture rd_addr into mem_addr and go to ISSUE; otherwise stay.
REQ-018 ISSUE: assert mem_en for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-019 WAIT: on mem_ack=1, load mem_rdata into Ro and go to DONE; otherwise increment the wait counter.
REQ-020 DONE: pulse rd_done for one cycle and return to IDLE.
REQ-021 busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE and DONE.
REQ-022 Minimum latency SHALL be 3 cycles from the rd_req sample to rd_done, with mem_ack in the first WAIT cycle.
REQ-023 rd_req in any state other than IDLE SHALL be ignored, with no queueing.
REQ-024 rd_req during DONE SHALL be ignored; a new read starts only from IDLE, so back-to-back reads take 4 cycles each.
REQ-025 mem_ack outside WAIT SHALL be ignored, and Ro SHALL NOT change.
REQ-026 Ro SHALL hold its value between reads and SHALL change only on mem_ack in WAIT.
REQ-027 mem_addr SHALL hold from capture until the next capture.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force IDLE, with busy=0, mem_en=0, rd_done=0, rd_err=0, mem_addr=0, Ro=0, and the wait counter at 0.
REQ-029 A reset mid-read SHALL abort the read; a later mem_ack SHALL be ignored, and no rd_done or rd_err is produced.
REQ-030 The first rd_req SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 With macro MEM_READ_TIMEOUT_EN defined, a wait counter that reaches TIMEOUT with no mem_ack SHALL cause a one-cycle rd_err pulse and a return to IDLE, with Ro unchanged and rd_done not pulsed.
REQ-032 With MEM_READ_TIMEOUT_EN defined, mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL take priority, completing the read normally.
REQ-033 Without MEM_READ_TIMEOUT_EN, WAIT SHALL persist until mem_ack, no counter SHALL be synthesized, and rd_err SHALL be tied to 0.

Verification
REQ-034 Reset, then rd_req with rd_addr=0x00A, and mem_ack with mem_rdata=0xAAAAA in the first WAIT cycle -> mem_en high one cycle with mem_addr=0x00A; Ro=0xAAAAA; rd_done pulses 3 cycles after the request.
REQ-035 mem_ack delayed 5 cycles with data 0x12345 -> busy high throughout; Ro=0x12345; single rd_done; Ro not changed before the ack.
REQ-036 rd_req held high for 10 cycles with immediate acks -> a new read every 4 cycles, and mem_addr tracks rd_addr at each IDLE sample.
REQ-037 rst_n pulsed low during WAIT, then mem_ack with data 0x55555 -> Ro=0, FSM in IDLE, no rd_done.
REQ-038 With MEM_READ_TIMEOUT_EN and no mem_ack -> rd_err pulses after TIMEOUT wait cycles, Ro keeps its previous value 0xAAAAA, and busy falls.
REQ-039 With MEM_READ_TIMEOUT_EN and mem_ack=1 exactly at count TIMEOUT -> rd_done pulses, rd_err stays 0, Ro is updated.
